dot_prod_feeder: RTL
====================

// Module: dot_prod_feeder
// PURPOSE
//  Source end of the dot-product sample stream. Holds a reference window (x) and a received-sample
//  buffer (y), then streams length-sample x/y pairs for successive y offsets ("shifts") into
//  dot_prod_pip's x/y tvalid/data inputs, honouring its tready. Sits between the CAF capture
//  logic and the dot_prod_pip correlation lane.
// PARAMETERS
//  xi_bits 12             ; reference sample I width
//  xq_bits 12             ; reference sample Q width
//  yi_bits 12             ; received sample I width
//  yq_bits 12             ; received sample Q width
//  length 5               ; samples per dot product (x buffer depth)
//  length_counter_bits 3  ; clog2(length)
//  buffer_length 16       ; y buffer depth
//  buffer_bits 4          ; clog2(buffer_length)
//  shift_bits 4           ; width of shift count/index
// PORTS
//  clk           in  1                 ; single clock, rising edge
//  rst_n         in  1                 ; asynchronous, active-low reset
//  wr_en         in  1                 ; buffer write strobe
//  wr_sel        in  1                 ; 0 = x buffer, 1 = y buffer
//  wr_addr       in  buffer_bits       ; write address
//  wr_i          in  max(xi,yi)_bits   ; write I (LSBs used for x)
//  wr_q          in  max(xq,yq)_bits   ; write Q (LSBs used for x)
//  start         in  1                 ; one-cycle run request
//  num_shifts    in  shift_bits        ; number of windows to stream
//  tready        in  1                 ; downstream ready (dot_prod_pip tready)
//  x_tvalid      out 1                 ; x beat valid
//  xi, xq        out xi_bits, xq_bits  ; reference sample
//  y_tvalid      out 1                 ; y beat valid (always equal to x_tvalid)
//  yi, yq        out yi_bits, yq_bits  ; received sample
//  tlast         out 1                 ; last beat of current window
//  shift_idx     out shift_bits        ; shift of current beat
//  busy          out 1                 ; run in progress
//  done          out 1                 ; one-cycle pulse, run complete
//  err           out 1                 ; one-cycle pulse, start rejected
// BEHAVIOUR
//  - Reset: x_tvalid = y_tvalid = tlast = busy = done = err = 0; xi/xq/yi/yq/shift_idx = 0;
//    FSM = IDLE. Buffer storage is not reset.
//  - Async assert aborts a run mid-window; no further beats until next start.
//  - Writes: honoured only in IDLE; ignored when busy. wr_sel=0 with wr_addr >= length ignored.
//  - FSM IDLE -> LOAD -> STREAM -> DONE -> IDLE.
//    IDLE: on start, if num_shifts + length - 1 > buffer_length then err pulse, stay IDLE;
//          if num_shifts == 0 then done pulse next cycle with no beats; else enter LOAD, busy = 1.
//    LOAD: one cycle; registers beat (s=0, k=0); sets valids.
//    STREAM: beat = x[k], y[s+k], tlast = (k == length-1), shift_idx = s.
//    DONE: busy = 0, done = 1 for one cycle.
//  - Handshake: a beat transfers on x_tvalid & tready. While valid & !tready, all outputs hold
//    stable. The next beat is presented the cycle after transfer (zero-bubble when tready held).
//  - Counters: k wraps length-1 -> 0 and s increments. Transfer of last beat (s = num_shifts-1,
//    k = length-1) drops valids next cycle and enters DONE.
//  - num_shifts is sampled at start; later changes are ignored. start while busy is ignored.
//  - Throughput: num_shifts*length beats; latency start -> first valid = 2 cycles.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE/LOAD/STREAM/DONE), WR_SEL_X/WR_SEL_Y.
//  - Sub-module: cpx_sample_ram (param width/depth, 1 write port, 1 async-read port),
//    instantiated twice for x and y. FSM and counters stay in the top.
// TESTING
//  - Load x = 1..5, y = 10..25; num_shifts = 3; tready = 1 -> 15 beats, no gaps.
//    Expect y = 10..14, 11..15, 12..16, tlast on beats 5/10/15, done 1 cycle after the last beat.
//  - Same run with tready toggled on a 1010... pattern -> identical beat sequence; outputs stable
//    during every !tready cycle.
//  - num_shifts = 13 (13+4 > 16) -> err pulse, busy stays 0, no valid.
//    num_shifts = 0 -> done pulse, no valid.
//  - rst_n low at beat 7 of the 1st test -> valid 0 immediately; a new start replays from s = 0,
//    with the buffers still holding the earlier data.
//  - wr_en and start asserted during busy -> no buffer change, run unaffected.
//  - Connect to dot_prod_pip (length = 5) with x = 1, y = 1..: i outputs 5*(s+3) for s = 0..2.

Source files
------------

// File: rtl/dot_prod_feeder_pkg.sv
// dot_prod_feeder_pkg: shared FSM states, write-select codes and
// default geometry for the dot-product sample feeder.
package dot_prod_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    localparam logic WR_SEL_X = 1'b0;
    localparam logic WR_SEL_Y = 1'b1;

    localparam int DEF_XI_BITS = 12;
    localparam int DEF_XQ_BITS = 12;
    localparam int DEF_YI_BITS = 12;
    localparam int DEF_YQ_BITS = 12;
    localparam int DEF_SHIFT_BITS = 4;

endpackage

// File: rtl/dot_prod_feeder_if.sv
// dot_prod_feeder_if: x/y sample stream into the correlation lane.
// master drives valids, samples, tlast, shift_idx; slave drives tready.
interface dot_prod_feeder_if #(
    parameter int XI_BITS    = dot_prod_feeder_pkg::DEF_XI_BITS,
    parameter int XQ_BITS    = dot_prod_feeder_pkg::DEF_XQ_BITS,
    parameter int YI_BITS    = dot_prod_feeder_pkg::DEF_YI_BITS,
    parameter int YQ_BITS    = dot_prod_feeder_pkg::DEF_YQ_BITS,
    parameter int SHIFT_BITS = dot_prod_feeder_pkg::DEF_SHIFT_BITS
);

    logic                  tready;
    logic                  x_tvalid;
    logic [XI_BITS-1:0]    xi;
    logic [XQ_BITS-1:0]    xq;
    logic                  y_tvalid;
    logic [YI_BITS-1:0]    yi;
    logic [YQ_BITS-1:0]    yq;
    logic                  tlast;
    logic [SHIFT_BITS-1:0] shift_idx;

    modport master (
        input  tready,
        output x_tvalid, xi, xq,
        output y_tvalid, yi, yq,
        output tlast, shift_idx
    );

    modport slave (
        output tready,
        input  x_tvalid, xi, xq,
        input  y_tvalid, yi, yq,
        input  tlast, shift_idx
    );

endinterface

// File: rtl/dot_prod_feeder_cpx_sample_ram.sv
// dot_prod_feeder_cpx_sample_ram: complex sample store, one write
// port, one async read port. Ports: clk, we/waddr/wdata, raddr/rdata.
module dot_prod_feeder_cpx_sample_ram #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    // Storage is deliberately not reset: contents survive rst_n.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dot_prod_feeder.sv
// dot_prod_feeder: streams x[k]/y[s+k] windows for successive shifts.
// Ports: clk, rst_n, buffer write bus, start/num_shifts, axis stream,
// busy/done/err status.
module dot_prod_feeder
    import dot_prod_feeder_pkg::*;
#(
    parameter int XI_BITS             = DEF_XI_BITS,
    parameter int XQ_BITS             = DEF_XQ_BITS,
    parameter int YI_BITS             = DEF_YI_BITS,
    parameter int YQ_BITS             = DEF_YQ_BITS,
    parameter int LENGTH              = 5,
    parameter int LENGTH_COUNTER_BITS = 3,
    parameter int BUFFER_LENGTH       = 16,
    parameter int BUFFER_BITS         = 4,
    parameter int SHIFT_BITS          = DEF_SHIFT_BITS,
    parameter int WR_I_BITS = (XI_BITS > YI_BITS) ? XI_BITS : YI_BITS,
    parameter int WR_Q_BITS = (XQ_BITS > YQ_BITS) ? XQ_BITS : YQ_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [BUFFER_BITS-1:0] wr_addr,
    input  logic [WR_I_BITS-1:0]   wr_i,
    input  logic [WR_Q_BITS-1:0]   wr_q,
    input  logic                   start,
    input  logic [SHIFT_BITS-1:0]  num_shifts,
    dot_prod_feeder_if.master      axis,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int XW = XI_BITS + XQ_BITS;
    localparam int YW = YI_BITS + YQ_BITS;
    localparam int KB = LENGTH_COUNTER_BITS;
    localparam logic [KB-1:0] K_LAST = KB'(LENGTH - 1);

    feeder_state_t state_q, state_d;

    logic [KB-1:0]         k_q, k_d, k_nxt;
    logic [SHIFT_BITS-1:0] s_q, s_d, s_nxt;
    logic [SHIFT_BITS-1:0] ns_q, ns_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d;
    logic                  valid_q, valid_d;
    logic                  tlast_q, tlast_d;
    logic                  err_q, err_d;
    logic [XI_BITS-1:0]    xi_q, xi_d;
    logic [XQ_BITS-1:0]    xq_q, xq_d;
    logic [YI_BITS-1:0]    yi_q, yi_d;
    logic [YQ_BITS-1:0]    yq_q, yq_d;

    logic in_idle;
    logic too_long;
    logic xfer;
    logic last_beat;
    logic load;
    logic x_we;
    logic y_we;

    logic [XW-1:0]          x_rdata;
    logic [YW-1:0]          y_rdata;
    logic [BUFFER_BITS-1:0] y_raddr;

    assign in_idle   = (state_q == ST_IDLE);
    assign too_long  = (int'(num_shifts) + LENGTH - 1) > BUFFER_LENGTH;
    assign xfer      = valid_q && axis.tready;
    assign last_beat = (s_q == ns_q - SHIFT_BITS'(1)) && (k_q == K_LAST);

    // Buffers are frozen for the whole run; x addresses past the
    // window would alias after truncation, so they are dropped.
    assign x_we = wr_en && in_idle && (wr_sel == WR_SEL_X)
               && (int'(wr_addr) < LENGTH);
    assign y_we = wr_en && in_idle && (wr_sel == WR_SEL_Y);

    dot_prod_feeder_cpx_sample_ram #(
        .WIDTH     (XW),
        .DEPTH     (LENGTH),
        .ADDR_BITS (KB)
    ) u_x_ram (
        .clk   (clk),
        .we    (x_we),
        .waddr (KB'(wr_addr)),
        .wdata ({wr_i[XI_BITS-1:0], wr_q[XQ_BITS-1:0]}),
        .raddr (k_nxt),
        .rdata (x_rdata)
    );

    dot_prod_feeder_cpx_sample_ram #(
        .WIDTH     (YW),
        .DEPTH     (BUFFER_LENGTH),
        .ADDR_BITS (BUFFER_BITS)
    ) u_y_ram (
        .clk   (clk),
        .we    (y_we),
        .waddr (wr_addr),
        .wdata ({wr_i[YI_BITS-1:0], wr_q[YQ_BITS-1:0]}),
        .raddr (y_raddr),
        .rdata (y_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !too_long) begin
                    state_d = (num_shifts == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:   state_d = ST_STREAM;
            ST_STREAM: begin
                if (xfer && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == ST_LOAD) || (state_q == ST_STREAM);
        done = (state_q == ST_DONE);
    end

    // Address of the beat to present next; the RAMs read async so
    // the beat registers capture it on the same edge.
    always_comb begin
        load  = 1'b0;
        k_nxt = '0;
        s_nxt = '0;
        if (state_q == ST_LOAD) begin
            load = 1'b1;
        end else if (state_q == ST_STREAM && xfer && !last_beat) begin
            load  = 1'b1;
            k_nxt = (k_q == K_LAST) ? '0 : k_q + KB'(1);
            s_nxt = (k_q == K_LAST) ? s_q + SHIFT_BITS'(1) : s_q;
        end
    end

    assign y_raddr = BUFFER_BITS'(s_nxt) + BUFFER_BITS'(k_nxt);

    always_comb begin
        k_d     = k_q;
        s_d     = s_q;
        ns_d    = ns_q;
        shift_d = shift_q;
        valid_d = valid_q;
        tlast_d = tlast_q;
        xi_d    = xi_q;
        xq_d    = xq_q;
        yi_d    = yi_q;
        yq_d    = yq_q;
        err_d   = 1'b0;
        if (in_idle && start) begin
            err_d = too_long;
            if (!too_long) begin
                ns_d = num_shifts;
            end
        end
        if (load) begin
            k_d          = k_nxt;
            s_d          = s_nxt;
            shift_d      = s_nxt;
            valid_d      = 1'b1;
            tlast_d      = (k_nxt == K_LAST);
            {xi_d, xq_d} = x_rdata;
            {yi_d, yq_d} = y_rdata;
        end else if (state_q == ST_STREAM && xfer) begin
            valid_d = 1'b0;
            tlast_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            s_q     <= '0;
            ns_q    <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            tlast_q <= 1'b0;
            err_q   <= 1'b0;
            xi_q    <= '0;
            xq_q    <= '0;
            yi_q    <= '0;
            yq_q    <= '0;
        end else begin
            k_q     <= k_d;
            s_q     <= s_d;
            ns_q    <= ns_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            tlast_q <= tlast_d;
            err_q   <= err_d;
            xi_q    <= xi_d;
            xq_q    <= xq_d;
            yi_q    <= yi_d;
            yq_q    <= yq_d;
        end
    end

    assign err            = err_q;
    assign axis.x_tvalid  = valid_q;
    assign axis.y_tvalid  = valid_q;
    assign axis.xi        = xi_q;
    assign axis.xq        = xq_q;
    assign axis.yi        = yi_q;
    assign axis.yq        = yq_q;
    assign axis.tlast     = tlast_q;
    assign axis.shift_idx = shift_q;

endmodule
